// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin bus arbiter driving a 2-to-4 tri-state decoder (sel/en/gnt).
// Optional hold-time limit with forced release is compiled in by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       tmo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic       r_en;
    logic       w_en_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic       r_tmo;
    logic       w_tmo_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [1:0] w_winner;
    logic       w_force;

    if (HOLD_MAX < 1) begin : g_hold_max_invalid
        $error("bus_arbiter_4: HOLD_MAX must be at least 1");
    end

    // Search starts just after the previous owner, so that owner ends up lowest priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_winner = rr_pick(r_last, req);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int                CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]     HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [3:0]    w_own_mask;

    assign w_own_mask = 4'b0001 << r_sel;
    assign w_force    = (r_cnt == HOLD_LIM) && ((req & ~w_own_mask) != 4'b0000);

    // Hold counter: 1 on the first GRANT cycle, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_state_nxt == GRANT) begin
            if (r_state != GRANT) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != HOLD_LIM) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end else begin
            r_cnt <= {CW{1'b0}};
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_en_nxt    = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE, TURN: begin
                if (req != 4'b0000) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_winner;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    w_state_nxt = TURN;
                    w_last_nxt  = r_sel;
                end else if (w_force) begin
                    w_state_nxt = TURN;
                    w_last_nxt  = r_sel;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_en_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_gnt_nxt = w_en_nxt ? (4'b0001 << w_sel_nxt) : 4'b0000;
    end

    // State and output registers; last_owner resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_gnt   <= 4'b0000;
            r_tmo   <= 1'b0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_gnt   <= w_gnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign sel = r_sel;
    assign en  = r_en;
    assign gnt = r_gnt;
    assign tmo = r_tmo;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Scoreboard bench for bus_arbiter_4: directed req vectors push hand-computed
// {en,sel,gnt,tmo} expectations; a monitor pops and compares after each rising edge.
module tb_bus_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       tmo;

    typedef struct {
        logic [7:0] v;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_id  = 0;
    logic       prev_en  = 1'b0;
    logic [1:0] prev_sel = 2'd0;
    logic [3:0] exp_g;

    bus_arbiter_4 #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .sel   (sel),
        .en    (en),
        .gnt   (gnt),
        .tmo   (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive req before the next rising edge and queue the outputs expected after it.
    task automatic step(input logic [3:0] r, input logic e, input logic [1:0] s,
                        input logic [3:0] g, input logic t);
        exp_t x;
        @(negedge clk);
        req  = r;
        x.v  = {e, s, g, t};
        x.id = step_id;
        step_id++;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare outputs just after each rising edge against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check($sformatf("step%0d {en,sel,gnt,tmo}", mon_e.id), {en, sel, gnt, tmo}, mon_e.v);
            end
        end
    end

    // Continuous structural checks on the decoder outputs.
    always @(negedge clk) begin
        check("gnt_onehot", {7'd0, ($countones(gnt) <= 1)}, 8'd1);
        exp_g = en ? (4'b0001 << sel) : 4'b0000;
        check("gnt_vs_sel_en", {4'd0, gnt}, {4'd0, exp_g});
        if (en && prev_en) begin
            check("owner_change_without_gap", {6'd0, sel}, {6'd0, prev_sel});
        end
        prev_en  = en;
        prev_sel = sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check("reset_state", {en, sel, gnt, tmo}, 8'b0_00_0000_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: grant after one edge, TURN, then IDLE.
        step(4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);

        // All requesting, each owner drops for one cycle: order 0,1,2,3,0.
        do_reset();
        step(4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b1110, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0);
        step(4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0);
        step(4'b1101, 1'b0, 2'd1, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0);
        step(4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0);
        step(4'b1011, 1'b0, 2'd2, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 2'd3, 4'b1000, 1'b0);
        step(4'b1111, 1'b1, 2'd3, 4'b1000, 1'b0);
        step(4'b0111, 1'b0, 2'd3, 4'b0000, 1'b0);
        step(4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);

        // Owner 2 drops as requester 3 rises: TURN, then 3 granted.
        step(4'b0100, 1'b1, 2'd2, 4'b0100, 1'b0);
        step(4'b0100, 1'b1, 2'd2, 4'b0100, 1'b0);
        step(4'b1000, 1'b0, 2'd2, 4'b0000, 1'b0);
        step(4'b1000, 1'b1, 2'd3, 4'b1000, 1'b0);
        step(4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a grant.
        step(4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0);
        step(4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'b1000;
        #1;
        check("async_reset_mid_grant", {en, sel, gnt, tmo}, 8'b0_00_0000_0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{v: 8'b1_11_1000_0, id: step_id});
        step_id++;
        step(4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0);

        // Two requesters held: forced release only when the hold limit is compiled in.
        do_reset();
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step(4'b0011, 1'b1, 2'd0, 4'b0001, 1'b0);
        end
        step(4'b0011, 1'b0, 2'd0, 4'b0000, 1'b1);
        step(4'b0011, 1'b1, 2'd1, 4'b0010, 1'b0);
        step(4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            step(4'b0011, 1'b1, 2'd0, 4'b0001, 1'b0);
        end
        step(4'b0010, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0);
        step(4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0);
`endif

        // Sole requester is never released and never pulses tmo.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0);
        end
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, which is the maximum number of consecutive GRANT cycles when timeout is compiled in.
REQ-002 The block SHALL have port clk  input  1  as its single clock, active on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  as its reset, asynchronous and active-low.
REQ-004 The block SHALL have port req  input  4  carrying the per-requester bus request, with bit i belonging to requester i.
REQ-005 The block SHALL have port sel  output  2  carrying the encoded owner index, which drives the 2-to-4 decoder select.
REQ-006 The block SHALL have port en  output  1  as the decoder enable, where 1 means exactly one tri-state driver is enabled.
REQ-007 The block SHALL have port gnt  output  4  carrying the one-hot grant, equal to (1<<sel) when en=1 and 0000 otherwise.
REQ-008 The block SHALL have port tmo  output  1  as a one-cycle pulse that marks a forced release.

Function
REQ-009 The block SHALL implement exactly three states: IDLE, GRANT and TURN (turnaround).
REQ-010 The block SHALL drive all outputs from registers, with no combinational path from req to any output.
REQ-011 In IDLE, the block SHALL hold en=0 and gnt=0000, and on a rising edge with req!=0000 it SHALL pick the round-robin winner and enter GRANT.
REQ-012 Round-robin order SHALL start at (last_owner+1) mod 4 and ascend with wrap-around, choosing the first index with req set.
REQ-013 Grant latency SHALL be one cycle: a req sampled at edge N SHALL make en, gnt and sel valid after edge N.
REQ-014 In GRANT, the block SHALL keep en=1 and keep sel stable while req[sel]=1, ignoring all other req bits.
REQ-015 When req[sel]=0 is sampled in GRANT, the block SHALL enter TURN, set en=0 and gnt=0000, and load last_owner=sel.
REQ-016 TURN SHALL last exactly one cycle with en=0 so that no two tri-state drivers overlap.
REQ-017 From TURN, the block SHALL arbitrate as in REQ-012 and enter GRANT if req!=0000, otherwise enter IDLE.
REQ-018 If the owner drops req in the same cycle another requester raises req, the block SHALL still pass through TURN, and the new requester SHALL be granted one cycle later.
REQ-019 A requester that drops req and re-raises it during TURN SHALL be treated as a new request with lowest priority.
REQ-020 While en=0, sel SHALL retain the last granted index.
REQ-021 At most one gnt bit SHALL be 1 in any cycle.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, set state=IDLE, en=0, gnt=0000, sel=00, tmo=0 and last_owner=3, giving requester 0 first priority.
REQ-023 Reset asserted during GRANT SHALL drop en on the same cycle without any turnaround.
REQ-024 After rst_n is released, the first arbitration SHALL occur at the first rising edge at which req!=0000.
REQ-025 When compiled in, the hold counter SHALL reset to 0.

Configuration
REQ-026 Timeout SHALL be compiled in by the macro BUS_ARB_TIMEOUT_EN.
REQ-027 With BUS_ARB_TIMEOUT_EN defined, the block SHALL count GRANT cycles from 1, and when the count equals HOLD_MAX while another req bit is set, it SHALL force a move to TURN, set last_owner=sel and pulse tmo=1 for one cycle.
REQ-028 With BUS_ARB_TIMEOUT_EN defined, when the owner is the only requester, the count SHALL saturate at HOLD_MAX and no release SHALL occur.
REQ-029 With BUS_ARB_TIMEOUT_EN undefined, the counter SHALL be absent, tmo SHALL be tied to 0, and a grant SHALL last as long as req[sel]=1.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then req=0001 at edge 1 -> sel=00, en=1, gnt=0001 after edge 1; req=0000 at edge 4 -> en=0 after edge 4, and IDLE from edge 5.
REQ-031 The bench SHALL cover this scenario: req=1111 held -> grant order 0,1,2,3,0, with each owner dropping req for one cycle after 2 cycles held, and en=0 for exactly one cycle between owners.
REQ-032 The bench SHALL cover this scenario: owner 2 drops req at the same edge req[3] rises -> TURN for one cycle, then gnt=1000.
REQ-033 The bench SHALL cover this scenario: rst_n pulled low mid-GRANT between clock edges -> en=0, gnt=0000, sel=00 with no clock edge; after release with req=1000 -> gnt=1000.
REQ-034 The bench SHALL cover this scenario, with BUS_ARB_TIMEOUT_EN and HOLD_MAX=8: req=0011 held -> owner 0 for 8 cycles, tmo=1 for one cycle, TURN, then gnt=0010; with req=0001 only, owner 0 is held indefinitely and tmo=0.
REQ-035 The bench SHALL check continuously that popcount(gnt)<=1, that gnt==(en ? 1<<sel : 0), and that en=0 for at least one cycle between any two different owners.
